// File: rtl/bot_io_pkg.sv
// Shared constants for the Rojobot PicoBlaze I/O register file:
// port addresses, interrupt bit positions and default sizing.
package bot_io_pkg;

  localparam int DEF_NUM_DIGITS = 8;
  localparam int DEF_LED_WIDTH  = 16;
  localparam int DEF_SW_WIDTH   = 16;
  localparam int DEF_NUM_BTNS   = 5;

  localparam logic [7:0] ADDR_BTN_LVL  = 8'h00;
  localparam logic [7:0] ADDR_BTN_EDGE = 8'h01;
  localparam logic [7:0] ADDR_SW0      = 8'h02;
  localparam logic [7:0] ADDR_SW1      = 8'h03;
  localparam logic [7:0] ADDR_LED0     = 8'h04;
  localparam logic [7:0] ADDR_LED1     = 8'h05;
  localparam logic [7:0] ADDR_LOCX     = 8'h08;
  localparam logic [7:0] ADDR_LOCY     = 8'h09;
  localparam logic [7:0] ADDR_BOTINFO  = 8'h0A;
  localparam logic [7:0] ADDR_SENSORS  = 8'h0B;
  localparam logic [7:0] ADDR_MOTCTL   = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h0D;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h0E;
  localparam logic [7:0] ADDR_DIG_BASE = 8'h20;
  localparam logic [7:0] ADDR_DP_BASE  = 8'h30;

  localparam int IRQ_UPD = 0;
  localparam int IRQ_BTN = 1;

  // Only the status-update source is enabled out of reset.
  localparam logic [1:0] IRQ_MASK_RST = 2'b01;

endpackage

// File: rtl/btn_edge_capture.sv
// Sticky rising-edge flags for the debounced pushbuttons, with
// clear-on-read of exactly the flags presented to the reader.
module btn_edge_capture #(
  parameter int NUM_BTNS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btns_i,
  input  logic                clr_i,
  output logic [NUM_BTNS-1:0] flags_o
);

  logic [NUM_BTNS-1:0] prev_q;
  logic [NUM_BTNS-1:0] flags_q;
  logic [NUM_BTNS-1:0] flags_d;
  logic [NUM_BTNS-1:0] rise;

  // A clearing read drops the flags it returned; an edge in the same cycle survives.
  always_comb begin
    rise    = btns_i & ~prev_q;
    flags_d = (clr_i ? '0 : flags_q) | rise;
  end

  // Previous-level register loads the live buttons in reset so a held button is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= btns_i;
      flags_q <= '0;
    end else begin
      prev_q  <= btns_i;
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/bot_io_regfile.sv
// PicoBlaze port-mapped register file bridging the Rojobot controller to
// botsim status, buttons, switches, LEDs, seven-segment digits and motors.
//
// Port bus: write_strobe qualifies port_id/out_port for exactly one cycle and
// the write lands on that edge. in_port follows port_id every cycle with one
// cycle of latency regardless of read_strobe; read_strobe only triggers read
// side effects (the BTN_EDGE clear).
module bot_io_regfile
  import bot_io_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int LED_WIDTH  = DEF_LED_WIDTH,
  parameter int SW_WIDTH   = DEF_SW_WIDTH,
  parameter int NUM_BTNS   = DEF_NUM_BTNS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              port_id,
  input  logic [7:0]              out_port,
  input  logic                    write_strobe,
  input  logic                    read_strobe,
  output logic [7:0]              in_port,
  output logic                    interrupt,
  input  logic                    interrupt_ack,
  input  logic                    upd_sysregs,
  input  logic [7:0]              loc_x,
  input  logic [7:0]              loc_y,
  input  logic [7:0]              bot_info,
  input  logic [7:0]              sensors,
  output logic [7:0]              mot_ctl,
  input  logic [NUM_BTNS-1:0]     db_btns,
  input  logic [SW_WIDTH-1:0]     db_sw,
  output logic [LED_WIDTH-1:0]    led,
  output logic [5*NUM_DIGITS-1:0] dig,
  output logic [NUM_DIGITS-1:0]   dp
);

  logic [7:0]            locx_q, locy_q, botinfo_q, sensors_q;
  logic [7:0]            mot_ctl_q;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [1:0]            mask_q;
  logic                  upd_q, upd_d, upd_clr;
  logic                  irq_q;
  logic [7:0]            in_port_q, rd_d;
  logic [NUM_BTNS-1:0]   edge_flags;
  logic                  edge_clr;
  logic [1:0]            irq_stat;
  logic [15:0]           led_wide, dp_wide, sw_wide;

  assign edge_clr = read_strobe && (port_id == ADDR_BTN_EDGE);

  btn_edge_capture #(.NUM_BTNS(NUM_BTNS)) u_btn_edge (
    .clk     (clk),
    .reset   (reset),
    .btns_i  (db_btns),
    .clr_i   (edge_clr),
    .flags_o (edge_flags)
  );

  always_comb begin
    irq_stat          = '0;
    irq_stat[IRQ_UPD] = upd_q;
    irq_stat[IRQ_BTN] = |edge_flags;
  end

  // Byte-lane writes into the LED and DP banks; bits beyond the parameter width drop off.
  always_comb begin
    led_wide = 16'(led_q);
    dp_wide  = 16'(dp_q);
    sw_wide  = 16'(db_sw);
    if (write_strobe && port_id == ADDR_LED0) led_wide[7:0]  = out_port;
    if (write_strobe && port_id == ADDR_LED1) led_wide[15:8] = out_port;
    if (write_strobe && port_id == ADDR_DP_BASE) dp_wide[7:0] = out_port;
    if (write_strobe && port_id == (ADDR_DP_BASE + 8'd1)) dp_wide[15:8] = out_port;
    led_d = led_wide[LED_WIDTH-1:0];
    dp_d  = dp_wide[NUM_DIGITS-1:0];
  end

  // Status snapshot: all four botsim inputs are captured together on the update pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      locx_q    <= '0;
      locy_q    <= '0;
      botinfo_q <= '0;
      sensors_q <= '0;
    end else if (upd_sysregs) begin
      locx_q    <= loc_x;
      locy_q    <= loc_y;
      botinfo_q <= bot_info;
      sensors_q <= sensors;
    end
  end

  // Writable output/config registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mot_ctl_q <= '0;
      led_q     <= '0;
      dp_q      <= '0;
      mask_q    <= IRQ_MASK_RST;
    end else begin
      led_q <= led_d;
      dp_q  <= dp_d;
      if (write_strobe && port_id == ADDR_MOTCTL)   mot_ctl_q <= out_port;
      if (write_strobe && port_id == ADDR_IRQ_MASK) mask_q    <= out_port[1:0];
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [4:0] dig_q;
    // One five-bit code register per digit.
    always_ff @(posedge clk) begin
      if (reset) dig_q <= '0;
      else if (write_strobe && port_id == 8'(ADDR_DIG_BASE + i)) dig_q <= out_port[4:0];
    end
    assign dig[5*i +: 5] = dig_q;
  end

  // UPD status: a new update pulse outranks an ack or write-1-clear in the same cycle.
  always_comb begin
    upd_clr = interrupt_ack ||
              (write_strobe && port_id == ADDR_IRQ_STAT && out_port[IRQ_UPD]);
    upd_d   = upd_sysregs || (upd_q && !upd_clr);
  end

  // Interrupt status and the registered interrupt level.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
      irq_q <= |(irq_stat & mask_q);
    end
  end

  // Read mux; anything unmapped or unimplemented reads as zero.
  always_comb begin
    rd_d = '0;
    case (port_id)
      ADDR_BTN_LVL:          rd_d = 8'(db_btns);
      ADDR_BTN_EDGE:         rd_d = 8'(edge_flags);
      ADDR_SW0:              rd_d = sw_wide[7:0];
      ADDR_SW1:              rd_d = sw_wide[15:8];
      ADDR_LED0:             rd_d = 16'(led_q) & 16'h00FF;
      ADDR_LED1:             rd_d = 8'(16'(led_q) >> 8);
      ADDR_LOCX:             rd_d = locx_q;
      ADDR_LOCY:             rd_d = locy_q;
      ADDR_BOTINFO:          rd_d = botinfo_q;
      ADDR_SENSORS:          rd_d = sensors_q;
      ADDR_MOTCTL:           rd_d = mot_ctl_q;
      ADDR_IRQ_STAT:         rd_d = {6'b0, irq_stat};
      ADDR_IRQ_MASK:         rd_d = {6'b0, mask_q};
      ADDR_DP_BASE:          rd_d = 8'(16'(dp_q) & 16'h00FF);
      ADDR_DP_BASE + 8'd1:   rd_d = 8'(16'(dp_q) >> 8);
      default:               rd_d = '0;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (port_id == 8'(ADDR_DIG_BASE + i)) rd_d = {3'b000, dig[5*i +: 5]};
    end
  end

  // Registered read data gives the one-cycle INPUT latency.
  always_ff @(posedge clk) begin
    if (reset) in_port_q <= '0;
    else       in_port_q <= rd_d;
  end

  assign in_port   = in_port_q;
  assign interrupt = irq_q;
  assign mot_ctl   = mot_ctl_q;
  assign led       = led_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_bot_io_regfile.sv
// Directed bench for bot_io_regfile with default sizing.
module tb_bot_io_regfile;

  logic        clk;
  logic        reset;
  logic [7:0]  port_id, out_port, in_port;
  logic        write_strobe, read_strobe;
  logic        interrupt, interrupt_ack, upd_sysregs;
  logic [7:0]  loc_x, loc_y, bot_info, sensors, mot_ctl;
  logic [4:0]  db_btns;
  logic [15:0] db_sw, led;
  logic [39:0] dig;
  logic [7:0]  dp;

  int vectors;
  int miscompares;
  logic [7:0]  got;
  logic [39:0] exp_dig;
  logic [7:0]  exp_q[$];

  localparam logic [7:0] SWEEP [31] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
    8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
    8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
    8'h28, 8'h2F, 8'h30, 8'h31, 8'h32, 8'h40, 8'hFF};

  bot_io_regfile dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .upd_sysregs(upd_sysregs),
    .loc_x(loc_x), .loc_y(loc_y), .bot_info(bot_info), .sensors(sensors),
    .mot_ctl(mot_ctl), .db_btns(db_btns), .db_sw(db_sw), .led(led),
    .dig(dig), .dp(dp)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    port_id = a; read_strobe = 1'b1;
    tick();
    d = in_port;
    read_strobe = 1'b0;
  endtask

  task automatic pulse_upd();
    upd_sysregs = 1'b1;
    tick();
    upd_sysregs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; db_btns = 5'b10000;
    tick(); tick();
    reset = 1'b0;
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b expected 0", interrupt); end
    vectors++;
    if (mot_ctl !== 8'h00) begin miscompares++; $display("FAIL rst_mot: got %h expected 00", mot_ctl); end
    vectors++;
    if (dig !== 40'h0) begin miscompares++; $display("FAIL rst_dig: got %h expected 0", dig); end
    vectors++;
    if (dp !== 8'h00) begin miscompares++; $display("FAIL rst_dp: got %h expected 00", dp); end
    vectors++;
    if (led !== 16'h0000) begin miscompares++; $display("FAIL rst_led: got %h expected 0000", led); end
    vectors++;
    io_read(8'h01, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL rst_held_btn_edge: got %h expected 00", got); end
    vectors++;
    io_read(8'h00, got);
    if (got !== 8'h10) begin miscompares++; $display("FAIL rst_btn_lvl: got %h expected 10", got); end
    vectors++;
    db_btns = 5'b00000;
    tick();
    for (int i = 0; i < 31; i++) exp_q.push_back((SWEEP[i] == 8'h0E) ? 8'h01 : 8'h00);
    for (int i = 0; i < 31; i++) begin
      logic [7:0] e;
      io_read(SWEEP[i], got);
      e = exp_q.pop_front();
      if (got !== e) begin miscompares++; $display("FAIL rst_sweep[%h]: got %h expected %h", SWEEP[i], got, e); end
      vectors++;
    end
  endtask

  task automatic test_snapshot();
    loc_x = 8'h12; loc_y = 8'h56; bot_info = 8'h9A; sensors = 8'hBC;
    pulse_upd();
    loc_x = 8'h34; loc_y = 8'h00; bot_info = 8'h00; sensors = 8'h00;
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL snap_irq_early: got %b expected 0", interrupt); end
    vectors++;
    tick();
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL snap_irq_rise: got %b expected 1", interrupt); end
    vectors++;
    io_read(8'h08, got);
    if (got !== 8'h12) begin miscompares++; $display("FAIL snap_locx: got %h expected 12", got); end
    vectors++;
    io_read(8'h09, got);
    if (got !== 8'h56) begin miscompares++; $display("FAIL snap_locy: got %h expected 56", got); end
    vectors++;
    io_read(8'h0A, got);
    if (got !== 8'h9A) begin miscompares++; $display("FAIL snap_botinfo: got %h expected 9a", got); end
    vectors++;
    io_read(8'h0B, got);
    if (got !== 8'hBC) begin miscompares++; $display("FAIL snap_sensors: got %h expected bc", got); end
    vectors++;
    io_read(8'h0D, got);
    if (got !== 8'h01) begin miscompares++; $display("FAIL snap_irq_stat: got %h expected 01", got); end
    vectors++;
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL ack_irq_hold: got %b expected 1", interrupt); end
    vectors++;
    tick();
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL ack_irq_fall: got %b expected 0", interrupt); end
    vectors++;
    io_read(8'h0D, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL ack_stat: got %h expected 00", got); end
    vectors++;
    // Writing 0 to bit0 must not clear; writing 1 must.
    pulse_upd();
    io_write(8'h0D, 8'h00);
    io_read(8'h0D, got);
    if (got !== 8'h01) begin miscompares++; $display("FAIL w0_noclear: got %h expected 01", got); end
    vectors++;
    io_write(8'h0D, 8'h01);
    tick();
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL w1c_irq: got %b expected 0", interrupt); end
    vectors++;
    io_read(8'h0D, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL w1c_stat: got %h expected 00", got); end
    vectors++;
  endtask

  task automatic test_buttons();
    db_btns = 5'b00100;
    tick();
    io_read(8'h01, got);
    if (got !== 8'h04) begin miscompares++; $display("FAIL btn2_edge: got %h expected 04", got); end
    vectors++;
    io_read(8'h01, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL btn2_cleared: got %h expected 00", got); end
    vectors++;
    db_btns = 5'b00000;
    tick();
    db_btns = 5'b01000;
    tick();
    io_read(8'h0D, got);
    if (got !== 8'h02) begin miscompares++; $display("FAIL btn_irq_stat: got %h expected 02", got); end
    vectors++;
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL btn_masked_irq: got %b expected 0", interrupt); end
    vectors++;
    // Button 1 rises on the same edge as the clearing read.
    db_btns = 5'b01010;
    io_read(8'h01, got);
    if (got !== 8'h08) begin miscompares++; $display("FAIL same_cycle_read: got %h expected 08", got); end
    vectors++;
    io_read(8'h01, got);
    if (got !== 8'h02) begin miscompares++; $display("FAIL same_cycle_kept: got %h expected 02", got); end
    vectors++;
    io_read(8'h01, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL same_cycle_clr: got %h expected 00", got); end
    vectors++;
    db_btns = 5'b00000;
    tick();
  endtask

  task automatic test_mask();
    io_write(8'h0E, 8'hFF);
    io_read(8'h0E, got);
    if (got !== 8'h03) begin miscompares++; $display("FAIL mask_width: got %h expected 03", got); end
    vectors++;
    io_write(8'h0E, 8'h02);
    io_read(8'h0E, got);
    if (got !== 8'h02) begin miscompares++; $display("FAIL mask_rd: got %h expected 02", got); end
    vectors++;
    pulse_upd();
    tick(); tick();
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL mask_upd_irq: got %b expected 0", interrupt); end
    vectors++;
    io_read(8'h0D, got);
    if (got !== 8'h01) begin miscompares++; $display("FAIL mask_upd_stat: got %h expected 01", got); end
    vectors++;
    db_btns = 5'b00001;
    tick();
    tick();
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL mask_btn_irq: got %b expected 1", interrupt); end
    vectors++;
    io_read(8'h01, got);
    if (got !== 8'h01) begin miscompares++; $display("FAIL mask_btn_edge: got %h expected 01", got); end
    vectors++;
    tick();
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL mask_btn_clr_irq: got %b expected 0", interrupt); end
    vectors++;
    io_write(8'h0D, 8'h01);
    io_write(8'h0E, 8'h01);
    db_btns = 5'b00000;
    tick(); tick();
    io_read(8'h0D, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL mask_cleanup: got %h expected 00", got); end
    vectors++;
  endtask

  task automatic test_outputs();
    db_sw = 16'hBEEF;
    io_read(8'h02, got);
    if (got !== 8'hEF) begin miscompares++; $display("FAIL sw0: got %h expected ef", got); end
    vectors++;
    io_read(8'h03, got);
    if (got !== 8'hBE) begin miscompares++; $display("FAIL sw1: got %h expected be", got); end
    vectors++;
    io_write(8'h04, 8'h5A);
    io_write(8'h05, 8'hC3);
    if (led !== 16'hC35A) begin miscompares++; $display("FAIL led_out: got %h expected c35a", led); end
    vectors++;
    io_read(8'h05, got);
    if (got !== 8'hC3) begin miscompares++; $display("FAIL led1_rd: got %h expected c3", got); end
    vectors++;
    io_write(8'h0C, 8'h3C);
    if (mot_ctl !== 8'h3C) begin miscompares++; $display("FAIL mot_out: got %h expected 3c", mot_ctl); end
    vectors++;
    io_read(8'h0C, got);
    if (got !== 8'h3C) begin miscompares++; $display("FAIL mot_rd: got %h expected 3c", got); end
    vectors++;
    io_write(8'h27, 8'h1F);
    exp_dig = 40'h1F;
    exp_dig = exp_dig << 35;
    if (dig !== exp_dig) begin miscompares++; $display("FAIL dig7: got %h expected %h", dig, exp_dig); end
    vectors++;
    io_write(8'h30, 8'hA5);
    if (dp !== 8'hA5) begin miscompares++; $display("FAIL dp0: got %h expected a5", dp); end
    vectors++;
    io_write(8'h28, 8'hFF);
    io_write(8'h31, 8'hFF);
    if (dig !== exp_dig) begin miscompares++; $display("FAIL dig_oob_wr: got %h expected %h", dig, exp_dig); end
    vectors++;
    if (dp !== 8'hA5) begin miscompares++; $display("FAIL dp_oob_wr: got %h expected a5", dp); end
    vectors++;
    io_read(8'h28, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL dig_oob_rd: got %h expected 00", got); end
    vectors++;
    io_write(8'h20, 8'hFF);
    exp_dig = exp_dig | 40'h1F;
    if (dig !== exp_dig) begin miscompares++; $display("FAIL dig0: got %h expected %h", dig, exp_dig); end
    vectors++;
    io_read(8'h20, got);
    if (got !== 8'h1F) begin miscompares++; $display("FAIL dig0_rd: got %h expected 1f", got); end
    vectors++;
    io_read(8'h30, got);
    if (got !== 8'hA5) begin miscompares++; $display("FAIL dp0_rd: got %h expected a5", got); end
    vectors++;
    io_read(8'h31, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL dp1_rd: got %h expected 00", got); end
    vectors++;
  endtask

  task automatic test_back_to_back();
    pulse_upd();
    tick();
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL b2b_irq_pre: got %b expected 1", interrupt); end
    vectors++;
    upd_sysregs = 1'b1; interrupt_ack = 1'b1;
    tick();
    upd_sysregs = 1'b0; interrupt_ack = 1'b0;
    tick();
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL b2b_irq_kept: got %b expected 1", interrupt); end
    vectors++;
    io_read(8'h0D, got);
    if (got !== 8'h01) begin miscompares++; $display("FAIL b2b_ack_stat: got %h expected 01", got); end
    vectors++;
    upd_sysregs = 1'b1;
    io_write(8'h0D, 8'h01);
    upd_sysregs = 1'b0;
    io_read(8'h0D, got);
    if (got !== 8'h01) begin miscompares++; $display("FAIL b2b_w1c_stat: got %h expected 01", got); end
    vectors++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL mid_rst_irq: got %b expected 0", interrupt); end
    vectors++;
    if (mot_ctl !== 8'h00 || led !== 16'h0000 || dig !== 40'h0 || dp !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_rst_outs: got mot=%h led=%h dig=%h dp=%h expected all 0", mot_ctl, led, dig, dp);
    end
    vectors++;
    io_read(8'h0D, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL mid_rst_stat: got %h expected 00", got); end
    vectors++;
    io_read(8'h0E, got);
    if (got !== 8'h01) begin miscompares++; $display("FAIL mid_rst_mask: got %h expected 01", got); end
    vectors++;
    io_read(8'h08, got);
    if (got !== 8'h00) begin miscompares++; $display("FAIL mid_rst_locx: got %h expected 00", got); end
    vectors++;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; upd_sysregs = 1'b0;
    loc_x = 8'h00; loc_y = 8'h00; bot_info = 8'h00; sensors = 8'h00;
    db_btns = 5'b00000; db_sw = 16'h0000;
    test_reset();
    test_snapshot();
    test_buttons();
    test_mask();
    test_outputs();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bot_io_regfile.md
# bot_io_regfile

Parametrised PicoBlaze I/O register file: the second-generation bridge between the Rojobot control PicoBlaze and the board/system peripherals. It keeps a consistent snapshot of the bot status registers and captures sticky button edges. It manages a maskable, acknowledgeable interrupt with two sources, and drives a configurable number of seven-segment digits, LEDs and motor control. It sits between the PicoBlaze port bus and the botsim, debouncer, and seven-segment driver.

## Interface
- NUM_DIGITS, 8: seven-segment digits driven (1..16).
- LED_WIDTH, 16: LED outputs (1..16).
- SW_WIDTH, 16: switch inputs (1..16).
- NUM_BTNS, 5: debounced pushbuttons (1..8).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- port_id  in  8  PicoBlaze port address.
- out_port  in  8  write data from PicoBlaze.
- write_strobe  in  1  one-cycle write qualifier.
- read_strobe  in  1  one-cycle read qualifier (side effects only).
- in_port  out  8  registered read data.
- interrupt  out  1  level interrupt to PicoBlaze.
- interrupt_ack  in  1  one-cycle acknowledge from PicoBlaze.
- upd_sysregs  in  1  one-cycle pulse: LocX/LocY/BotInfo/Sensors valid.
- loc_x, loc_y, bot_info, sensors  in  8 each  botsim status.
- mot_ctl  out  8  motor control to botsim.
- db_btns  in  NUM_BTNS  debounced buttons.
- db_sw  in  SW_WIDTH  debounced switches.
- led  out  LED_WIDTH  LED drive.
- dig  out  5*NUM_DIGITS  digit codes; digit i at [5i+4:5i].
- dp  out  NUM_DIGITS  decimal points.

## Operation
- Address map:
  - 0x00 BTN_LVL (R).
  - 0x01 BTN_EDGE (R, clear-on-read).
  - 0x02/0x03 SW bytes 0/1 (R).
  - 0x04/0x05 LED bytes 0/1 (RW).
  - 0x08 LOCX, 0x09 LOCY, 0x0A BOTINFO, 0x0B SENSORS (R, snapshot).
  - 0x0C MOTCTL (RW).
  - 0x0D IRQ_STAT (R, write-1-clear bit0).
  - 0x0E IRQ_MASK (RW, bits[1:0]).
  - 0x20+i DIG[i] (RW, bits[4:0], i<NUM_DIGITS).
  - 0x30+k DP byte k (RW, dp[8k+7:8k]).
- Unmapped reads, unimplemented bits, and bits beyond a parameter width read 0. Unmapped writes are ignored.
- Snapshot: the upd_sysregs pulse latches all four status inputs together into shadow registers. Reads return only the shadows, so a read never sees a torn update.
- Button edges: a 0→1 transition on db_btns[j] sets sticky flag j.
  - A read of 0x01 with read_strobe clears the flags that were returned.
  - A flag set in the same cycle as the clearing read stays set.
- IRQ_STAT bit0 (UPD) is set by upd_sysregs. It is cleared by interrupt_ack or by writing 1 to bit0 at 0x0D.
  - Set and clear in the same cycle: set wins.
- IRQ_STAT bit1 (BTN) = OR of the edge flags. It is read-only and clears only through BTN_EDGE reads.
- interrupt is registered: interrupt = |(IRQ_STAT & IRQ_MASK).
- Reset values:
  - in_port, mot_ctl, led, dig, dp: 0.
  - interrupt: 0.
  - shadows, edge flags, IRQ_STAT: 0.
  - IRQ_MASK: 0x01.
  - The previous-button register loads db_btns, so a button already held at reset does not produce an edge.

## Timing
- Read: port_id sampled at edge N; in_port valid after edge N and held until the next edge. This is the 1-cycle latency PicoBlaze INPUT requires.
- Write: takes effect on the edge where write_strobe is high; output visible the next cycle.
- upd_sysregs high at edge N:
  - shadows and UPD bit update at N;
  - interrupt rises at N+1 if the source is masked in.
- interrupt_ack at edge N clears UPD at N; interrupt falls at N+1 unless another masked source is pending.
- Clear-on-read acts on the read_strobe edge and uses the same-cycle flag value presented on in_port.
- Reset mid-operation: all state returns to its reset value on the next edge, and pending interrupts are discarded.

## Structure
- Package bot_io_pkg holds:
  - address constants (ADDR_BTN_LVL … ADDR_DP_BASE);
  - IRQ bit indices IRQ_UPD=0 and IRQ_BTN=1;
  - default parameter values.
- Sub-module btn_edge_capture (parameter NUM_BTNS) holds:
  - the previous-state register;
  - the sticky flags;
  - clear-on-read mask handling.
- Top level contains:
  - the address decoder;
  - the read mux;
  - the output registers;
  - the snapshot shadows;
  - the IRQ logic.
- Digit and DP registers are generated from NUM_DIGITS.

## Test plan
- Reset, then read every address → 0, except IRQ_MASK=0x01. Also check mot_ctl=0, dig=0, interrupt=0.
- Drive loc_x=0x12 and pulse upd_sysregs. Change loc_x to 0x34 without a pulse, then read 0x08 → 0x12. interrupt rises 1 cycle after the pulse; interrupt_ack drops it the following cycle.
- Press button 2 (0→1) and read 0x01 → 0x04, then read again → 0x00. An edge arriving in the same cycle as the read stays set.
- Set IRQ_MASK=0x02 and pulse upd_sysregs → interrupt stays 0. Press button 0 → interrupt=1. Clear via a BTN_EDGE read → interrupt=0.
- With NUM_DIGITS=8, write 0x27=0x1F and 0x30=0xA5 → dig[39:35]=5'h1F, dp=8'hA5. A write to 0x28 changes nothing.
- upd_sysregs and interrupt_ack in the same cycle → UPD remains set and interrupt stays asserted.
